// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width and width-generic Gray/binary conversion.
// Vectors up to MAX_W bits are handled; callers zero-extend and truncate to their width.
package fifo_pkg;

    localparam int unsigned MAX_W = 32;

    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // XOR prefix from the MSB down; zero-extended upper bits leave the result unchanged
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
        logic [MAX_W-1:0] bin;
        bin[MAX_W-1] = gray[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter of parametrised width.
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    assign o_bin = W'(gray2bin(MAX_W'(i_gray)));

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer and flag controller for the async FIFO: pointers, empty,
// level, almost-empty and sticky underflow, all updated from the next pointer.
module fifo_rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 3,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   sync_w2r_ptr,
    input  logic                  runderflow_clr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rd_en,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  runderflow
);

    localparam int unsigned PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rptr_gray;
    logic          r_rempty;
    logic          r_raempty;
    logic [PW-1:0] r_rlevel;
    logic          r_runderflow;

    logic          w_rd_en;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_level_next;
    logic          w_uf_set;

    assign w_rd_en      = rinc & ~r_rempty;
    assign w_uf_set     = rinc & r_rempty;
    assign w_rbin_next  = r_rbin + {{(PW-1){1'b0}}, w_rd_en};
    assign w_rgray_next = PW'(bin2gray(MAX_W'(w_rbin_next)));

    gray2bin_conv #(
        .W (PW)
    ) u_wptr_g2b (
        .i_gray (sync_w2r_ptr),
        .o_bin  (w_wbin)
    );

    // Level is taken against the next read pointer so a same-cycle read and write both count once
    assign w_level_next = w_wbin - w_rbin_next;

    // Pointer, flag and level registers with synchronous reset
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rbin       <= '0;
            r_rptr_gray  <= '0;
            r_rempty     <= 1'b1;
            r_raempty    <= 1'b1;
            r_rlevel     <= '0;
            r_runderflow <= 1'b0;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rptr_gray <= w_rgray_next;
            r_rempty    <= (w_rgray_next == sync_w2r_ptr);
            r_raempty   <= (w_level_next <= THRESH);
            r_rlevel    <= w_level_next;
            if (w_uf_set) begin
                r_runderflow <= 1'b1;
            end else if (runderflow_clr) begin
                r_runderflow <= 1'b0;
            end else begin
                r_runderflow <= r_runderflow;
            end
        end
    end

    assign rptr_gray  = r_rptr_gray;
    assign raddr      = r_rbin[ADDR_WIDTH-1:0];
    assign rd_en      = w_rd_en;
    assign rempty     = r_rempty;
    assign raempty    = r_raempty;
    assign rlevel     = r_rlevel;
    assign runderflow = r_runderflow;

endmodule
